axi_lite_ipif_slave: RTL and testbench

AXI4-Lite responder that terminates register-access transactions issued by an AXI4-Lite master and converts each one into a single-beat IPIF-style register bus cycle towards a local register bank. It is the slave-side counterpart of the IPIF-to-AXI4-Lite master used by the DMA register interface, and it sits between the AXI4-Lite interconnect and a pcore's user registers. The block handles one transaction at a time and returns a response for every accepted request. It provides address-range decode, a bounded-latency timeout, and read/write fairness.

---
 rtl/axi_lite_ipif_slave_if.sv | 48 ++++
 rtl/axi_lite_ipif_slave.sv | 152 +++++++++++++++
 tb/tb_axi_lite_ipif_slave.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_ipif_slave_if.sv
// Bundles the AXI4-Lite slave channels and the IPIF register-bus side of axi_lite_ipif_slave.
// The slave modport is the bridge itself; the master modport is whoever drives AXI and plays the IP.
interface axi_lite_ipif_slave_if;
  logic [31:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [31:0] Bus2IP_Addr;
  logic [31:0] Bus2IP_Data;
  logic [3:0]  Bus2IP_BE;
  logic        Bus2IP_RNW;
  logic        Bus2IP_CS;
  logic [31:0] IP2Bus_Data;
  logic        IP2Bus_RdAck;
  logic        IP2Bus_WrAck;
  logic        IP2Bus_Error;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output Bus2IP_Addr, Bus2IP_Data, Bus2IP_BE, Bus2IP_RNW, Bus2IP_CS,
    input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  Bus2IP_Addr, Bus2IP_Data, Bus2IP_BE, Bus2IP_RNW, Bus2IP_CS,
    output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );
endinterface

// File: rtl/axi_lite_ipif_slave.sv
// AXI4-Lite responder that turns each accepted read or write into one IPIF register cycle,
// with address decode, acknowledge timeout and read/write alternation when both are pending.
module axi_lite_ipif_slave #(
  parameter logic [31:0] C_BASEADDR = 32'hffffffff,
  parameter logic [31:0] C_HIGHADDR = 32'h0,
  parameter int          C_TIMEOUT  = 64
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESET,
  axi_lite_ipif_slave_if.slave        bus
);

  localparam logic [7:0] TMO_LAST = 8'(C_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCEPT, REQ, RESP} state_t;

  state_t      state, state_next;
  logic        cur_read;
  logic        last_read;
  logic [7:0]  tcount;

  logic        rd_pend, wr_pend;
  logic        start, grant_read;
  logic [31:0] addr_sel;
  logic        in_range;
  logic        match_ack;
  logic        resp_load;
  logic [1:0]  resp_code;
  logic [31:0] resp_rdata;
  logic        done;

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) state <= IDLE;
    else              state <= state_next;
  end

  // last_read starts at 0 so that, with both pending after reset, the read wins.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    grant_read = 1'b0;
    match_ack  = 1'b0;
    resp_load  = 1'b0;
    resp_code  = 2'b00;
    resp_rdata = 32'h0;
    done       = 1'b0;
    rd_pend    = bus.S_AXI_ARVALID;
    wr_pend    = bus.S_AXI_AWVALID & bus.S_AXI_WVALID;
    addr_sel   = cur_read ? bus.S_AXI_ARADDR : bus.S_AXI_AWADDR;
    in_range   = (addr_sel >= C_BASEADDR) && (addr_sel <= C_HIGHADDR);
    case (state)
      IDLE: begin
        if (rd_pend && (!wr_pend || !last_read)) begin
          start      = 1'b1;
          grant_read = 1'b1;
          state_next = ACCEPT;
        end else if (wr_pend) begin
          start      = 1'b1;
          state_next = ACCEPT;
        end
      end
      ACCEPT: begin
        if (in_range) begin
          state_next = REQ;
        end else begin
          resp_load  = 1'b1;
          resp_code  = 2'b11;
          state_next = RESP;
        end
      end
      REQ: begin
        match_ack = cur_read ? bus.IP2Bus_RdAck : bus.IP2Bus_WrAck;
        if (match_ack) begin
          resp_load  = 1'b1;
          resp_code  = bus.IP2Bus_Error ? 2'b10 : 2'b00;
          resp_rdata = bus.IP2Bus_Data;
          state_next = RESP;
        end else if (tcount == TMO_LAST) begin
          resp_load  = 1'b1;
          resp_code  = 2'b10;
          state_next = RESP;
        end
      end
      RESP: begin
        done = cur_read ? bus.S_AXI_RREADY : bus.S_AXI_BREADY;
        if (done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Every output is a flop; READYs and CS are loaded from the decision made in the state before.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      cur_read          <= 1'b0;
      last_read         <= 1'b0;
      tcount            <= 8'd0;
      bus.S_AXI_ARREADY <= 1'b0;
      bus.S_AXI_AWREADY <= 1'b0;
      bus.S_AXI_WREADY  <= 1'b0;
      bus.S_AXI_BRESP   <= 2'b00;
      bus.S_AXI_BVALID  <= 1'b0;
      bus.S_AXI_RDATA   <= 32'h0;
      bus.S_AXI_RRESP   <= 2'b00;
      bus.S_AXI_RVALID  <= 1'b0;
      bus.Bus2IP_Addr   <= 32'h0;
      bus.Bus2IP_Data   <= 32'h0;
      bus.Bus2IP_BE     <= 4'h0;
      bus.Bus2IP_RNW    <= 1'b0;
      bus.Bus2IP_CS     <= 1'b0;
    end else begin
      bus.S_AXI_ARREADY <= start & grant_read;
      bus.S_AXI_AWREADY <= start & ~grant_read;
      bus.S_AXI_WREADY  <= start & ~grant_read;
      bus.Bus2IP_CS     <= (state_next == REQ);

      if (start) begin
        cur_read  <= grant_read;
        last_read <= grant_read;
      end

      if (state == ACCEPT) begin
        bus.Bus2IP_RNW  <= cur_read;
        bus.Bus2IP_Addr <= addr_sel;
        if (cur_read) begin
          bus.Bus2IP_BE <= 4'hF;
        end else begin
          bus.Bus2IP_BE   <= bus.S_AXI_WSTRB;
          bus.Bus2IP_Data <= bus.S_AXI_WDATA;
        end
      end

      if (state == REQ) tcount <= tcount + 8'd1;
      else if (done)    tcount <= 8'd0;

      if (resp_load) begin
        if (cur_read) begin
          bus.S_AXI_RVALID <= 1'b1;
          bus.S_AXI_RRESP  <= resp_code;
          bus.S_AXI_RDATA  <= resp_rdata;
        end else begin
          bus.S_AXI_BVALID <= 1'b1;
          bus.S_AXI_BRESP  <= resp_code;
        end
      end else if (done) begin
        bus.S_AXI_RVALID <= 1'b0;
        bus.S_AXI_BVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_ipif_slave.sv
// Directed bench for axi_lite_ipif_slave: arbitration, IPIF cycles, decode error, timeout,
// backpressure and mid-transaction reset, each step with hand-computed expectations.
module tb_axi_lite_ipif_slave;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] HIGH = 32'h4000_00FF;
  localparam int          TMO  = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   cs_cnt;

  axi_lite_ipif_slave_if bus ();

  axi_lite_ipif_slave #(
    .C_BASEADDR (BASE),
    .C_HIGHADDR (HIGH),
    .C_TIMEOUT  (TMO)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .bus          (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB   = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    bus.IP2Bus_Data  = '0; bus.IP2Bus_RdAck  = 1'b0;
    bus.IP2Bus_WrAck = 1'b0; bus.IP2Bus_Error = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
    check("rst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    check("rst_wready",  32'(bus.S_AXI_WREADY),  32'd0);
    check("rst_valids",  32'({bus.S_AXI_RVALID, bus.S_AXI_BVALID}), 32'd0);
    check("rst_resps",   32'({bus.S_AXI_RRESP, bus.S_AXI_BRESP}), 32'd0);
    check("rst_rdata",   bus.S_AXI_RDATA, 32'd0);
    check("rst_cs",      32'(bus.Bus2IP_CS), 32'd0);
    check("rst_ipif",    32'({bus.Bus2IP_Addr[15:0], bus.Bus2IP_BE, bus.Bus2IP_RNW}), 32'd0);

    // Both request types pending from reset: read first, then write, then read again
    bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_ARADDR = BASE + 32'h8;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_AWADDR = BASE + 32'h4;
    bus.S_AXI_WVALID  = 1'b1; bus.S_AXI_WDATA  = 32'hA5A5_0001; bus.S_AXI_WSTRB = 4'h3;
    rst = 1'b0;
    tick();
    check("arb1_arready", 32'(bus.S_AXI_ARREADY), 32'd1);
    check("arb1_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    tick();
    check("arb1_cs",   32'(bus.Bus2IP_CS), 32'd1);
    check("arb1_addr", bus.Bus2IP_Addr, BASE + 32'h8);
    check("arb1_be",   32'(bus.Bus2IP_BE), 32'hF);
    check("arb1_rnw",  32'(bus.Bus2IP_RNW), 32'd1);
    bus.IP2Bus_RdAck = 1'b1; bus.IP2Bus_Data = 32'h0BAD_F00D;
    tick();
    bus.IP2Bus_RdAck = 1'b0;
    check("arb1_rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
    check("arb1_rdata",  bus.S_AXI_RDATA, 32'h0BAD_F00D);
    check("arb1_rresp",  32'(bus.S_AXI_RRESP), 32'd0);
    check("arb1_cs_off", 32'(bus.Bus2IP_CS), 32'd0);
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    check("arb1_rvalid_off", 32'(bus.S_AXI_RVALID), 32'd0);
    tick();
    check("arb2_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    check("arb2_wready",  32'(bus.S_AXI_WREADY),  32'd1);
    check("arb2_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;

    // Write acked in the third CS cycle
    cs_cnt = 0;
    tick();
    check("wr_addr", bus.Bus2IP_Addr, BASE + 32'h4);
    check("wr_data", bus.Bus2IP_Data, 32'hA5A5_0001);
    check("wr_be",   32'(bus.Bus2IP_BE), 32'h3);
    check("wr_rnw",  32'(bus.Bus2IP_RNW), 32'd0);
    if (bus.Bus2IP_CS) cs_cnt++;
    tick();
    if (bus.Bus2IP_CS) cs_cnt++;
    tick();
    if (bus.Bus2IP_CS) cs_cnt++;
    bus.IP2Bus_WrAck = 1'b1;
    tick();
    bus.IP2Bus_WrAck = 1'b0;
    if (bus.Bus2IP_CS) cs_cnt++;
    check("wr_cs_cycles", 32'(cs_cnt), 32'd3);
    check("wr_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    check("wr_bresp",  32'(bus.S_AXI_BRESP), 32'd0);
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    check("wr_bvalid_off", 32'(bus.S_AXI_BVALID), 32'd0);

    // Read again (ARVALID still held) and the IP flags an error
    tick();
    check("arb3_arready", 32'(bus.S_AXI_ARREADY), 32'd1);
    bus.S_AXI_ARVALID = 1'b0;
    tick();
    bus.IP2Bus_RdAck = 1'b1; bus.IP2Bus_Error = 1'b1; bus.IP2Bus_Data = 32'hDEAD_BEEF;
    tick();
    bus.IP2Bus_RdAck = 1'b0; bus.IP2Bus_Error = 1'b0;
    check("err_rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
    check("err_rresp",  32'(bus.S_AXI_RRESP), 32'h2);
    check("err_rdata",  bus.S_AXI_RDATA, 32'hDEAD_BEEF);
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;

    // Read of the written address with 4 cycles of RREADY backpressure
    bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_ARADDR = BASE + 32'h4;
    tick();
    check("rd_arready", 32'(bus.S_AXI_ARREADY), 32'd1);
    bus.S_AXI_ARVALID = 1'b0;
    tick();
    bus.IP2Bus_RdAck = 1'b1; bus.IP2Bus_Data = 32'h1234_5678;
    tick();
    bus.IP2Bus_RdAck = 1'b1; bus.IP2Bus_Data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      check("bp_rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
      check("bp_rdata",  bus.S_AXI_RDATA, 32'h1234_5678);
      check("bp_rresp",  32'(bus.S_AXI_RRESP), 32'd0);
      tick();
      bus.IP2Bus_RdAck = 1'b0;
    end
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    check("bp_rvalid_off", 32'(bus.S_AXI_RVALID), 32'd0);

    // Decode error: CS never rises, response valid in cycle 2
    bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_ARADDR = HIGH + 32'h4;
    tick();
    check("dec_arready", 32'(bus.S_AXI_ARREADY), 32'd1);
    check("dec_cs1",     32'(bus.Bus2IP_CS), 32'd0);
    bus.S_AXI_ARVALID = 1'b0;
    tick();
    check("dec_rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
    check("dec_rresp",  32'(bus.S_AXI_RRESP), 32'h3);
    check("dec_cs2",    32'(bus.Bus2IP_CS), 32'd0);
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;

    // AW without W must not be accepted; then an unacked write times out
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_AWADDR = BASE + 32'h10;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("aw_only_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    end
    bus.S_AXI_WVALID = 1'b1; bus.S_AXI_WDATA = 32'h5555_AAAA; bus.S_AXI_WSTRB = 4'hF;
    tick();
    check("aw_w_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    check("aw_w_wready",  32'(bus.S_AXI_WREADY),  32'd1);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    tick();
    cs_cnt = 0;
    while (bus.Bus2IP_CS && cs_cnt < 20) begin
      cs_cnt++;
      tick();
    end
    check("tmo_cs_cycles", 32'(cs_cnt), 32'd8);
    check("tmo_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    check("tmo_bresp",  32'(bus.S_AXI_BRESP), 32'h2);
    bus.IP2Bus_WrAck = 1'b1;
    tick();
    bus.IP2Bus_WrAck = 1'b0;
    check("late_ack_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    check("late_ack_bresp",  32'(bus.S_AXI_BRESP), 32'h2);
    check("late_ack_cs",     32'(bus.Bus2IP_CS), 32'd0);
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    check("tmo_bvalid_off", 32'(bus.S_AXI_BVALID), 32'd0);

    // Reset while a read holds CS; arbitration history must restart at read-first
    bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_ARADDR = BASE + 32'h20;
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    tick();
    check("pre_rst_cs", 32'(bus.Bus2IP_CS), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_cs",   32'(bus.Bus2IP_CS), 32'd0);
    check("mid_rst_addr", bus.Bus2IP_Addr, 32'd0);
    check("mid_rst_misc", 32'({bus.Bus2IP_BE, bus.Bus2IP_RNW, bus.S_AXI_RVALID, bus.S_AXI_ARREADY}), 32'd0);
    tick();
    bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_ARADDR = BASE + 32'h24;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_AWADDR = BASE + 32'h28;
    bus.S_AXI_WVALID  = 1'b1;
    rst = 1'b0;
    tick();
    check("post_rst_arready", 32'(bus.S_AXI_ARREADY), 32'd1);
    check("post_rst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    tick();
    check("post_rst_addr", bus.Bus2IP_Addr, BASE + 32'h24);
    bus.IP2Bus_RdAck = 1'b1; bus.IP2Bus_Data = 32'hCAFE_F00D;
    tick();
    bus.IP2Bus_RdAck = 1'b0;
    check("post_rst_rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
    check("post_rst_rdata",  bus.S_AXI_RDATA, 32'hCAFE_F00D);
    check("post_rst_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
